bypass_fwd_unit: RTL and testbench

- Parametrised operand-bypass unit for the RV32I core; generalises the single-operand pass-through to two operands with a forwarding history.
- Tracks the last DEPTH in-flight register writebacks in a shift history.
- Forwards the youngest matching value to rs1/rs2; stalls on a load-use hazard until the load data returns.
- Sits between the register-file read and the execute operand inputs.

---
 rtl/bypass_fwd_unit_pkg.sv | 36 +++
 rtl/bypass_fwd_unit_match.sv | 81 ++++++++
 rtl/bypass_fwd_unit.sv | 164 ++++++++++++++++
 tb/tb_bypass_fwd_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bypass_fwd_unit_pkg.sv
// -----------------------------------------------------------------------------
// bypass_fwd_unit_pkg
// Shared defaults and history-entry layout for the operand-bypass unit.
//
// A history entry is a flat vector laid out LSB first as
//   data[XLEN] | addr[REG_AW] | pending | valid
// The helper functions return bit offsets so that every user slices
// entries the same way whatever XLEN and REG_AW are.
// -----------------------------------------------------------------------------
package bypass_fwd_unit_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  // x0 is hard-wired to zero and is never forwarded.
  localparam int X0_ADDR = 0;

  localparam int ENT_DATA_LSB = 0;

  function automatic int ent_addr_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int ent_pend_bit(input int xlen, input int aw);
    return xlen + aw;
  endfunction

  function automatic int ent_valid_bit(input int xlen, input int aw);
    return xlen + aw + 1;
  endfunction

  function automatic int ent_width(input int xlen, input int aw);
    return xlen + aw + 2;
  endfunction

endpackage

// File: rtl/bypass_fwd_unit_match.sv
// -----------------------------------------------------------------------------
// bypass_match
// Resolves one source operand against the incoming write and the writeback
// history. The youngest candidate whose address matches wins. If it still
// waits for load data, the operand falls back to the register file and a
// stall is raised.
//
// Ports
//   i_hist       flattened history, slot 0 (newest) in the low entry
//   i_wr_valid   incoming write is a candidate (already gated by reset)
//   i_wr_is_load incoming write carries no data yet
//   i_wr_addr    incoming write destination
//   i_wr_data    incoming write data
//   i_rs_addr    source register to resolve
//   i_rf_data    register-file read data for i_rs_addr
//   o_op         resolved operand
//   o_hit        operand was forwarded
//   o_stall      youngest match is still pending
// -----------------------------------------------------------------------------
module bypass_match
  import bypass_fwd_unit_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW,
  parameter int DEPTH  = 3
) (
  input  logic [DEPTH*ent_width(XLEN, REG_AW)-1:0] i_hist,
  input  logic                                     i_wr_valid,
  input  logic                                     i_wr_is_load,
  input  logic [REG_AW-1:0]                        i_wr_addr,
  input  logic [XLEN-1:0]                          i_wr_data,
  input  logic [REG_AW-1:0]                        i_rs_addr,
  input  logic [XLEN-1:0]                          i_rf_data,
  output logic [XLEN-1:0]                          o_op,
  output logic                                     o_hit,
  output logic                                     o_stall
);

  localparam int EW = ent_width(XLEN, REG_AW);
  localparam int AL = ent_addr_lsb(XLEN);
  localparam int PB = ent_pend_bit(XLEN, REG_AW);
  localparam int VB = ent_valid_bit(XLEN, REG_AW);

  logic          found;
  logic [EW-1:0] ent;

  always_comb begin
    // NOTE: every variable gets a default before the search, so no path
    // through the priority chain can leave one unassigned and infer a latch.
    o_op    = i_rf_data;
    o_hit   = 1'b0;
    o_stall = 1'b0;
    found   = 1'b0;
    ent     = '0;
    if (i_rs_addr != REG_AW'(X0_ADDR)) begin
      // The write entering the pipeline this cycle is younger than any slot.
      if (i_wr_valid && (i_wr_addr == i_rs_addr)) begin
        found = 1'b1;
        if (i_wr_is_load) begin
          o_stall = 1'b1;
        end else begin
          o_op  = i_wr_data;
          o_hit = 1'b1;
        end
      end
      for (int k = 0; k < DEPTH; k++) begin
        ent = i_hist[k*EW +: EW];
        if (!found && ent[VB] && (ent[AL +: REG_AW] == i_rs_addr)) begin
          found = 1'b1;
          if (ent[PB]) begin
            o_stall = 1'b1;
          end else begin
            o_op  = ent[ENT_DATA_LSB +: XLEN];
            o_hit = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bypass_fwd_unit.sv
// -----------------------------------------------------------------------------
// bypass_fwd_unit
// Two-operand bypass for the RV32I core. Keeps the last DEPTH writebacks in a
// shift history and forwards the youngest matching value to rs1/rs2. A match
// on a load whose data has not returned stalls decode.
//
// Ports
//   i_clk, i_rstn       clock, asynchronous active-low reset
//   i_flush             drop all history (and the write of this cycle)
//   i_wr_*              write entering the pipeline this cycle
//   i_ld_valid/data     returned load data for the single pending entry
//   i_rs1/2_addr        source registers
//   i_rf_rs1/2          register-file read data
//   o_opA/o_opB         resolved operands
//   o_stall             load-use hazard
//   o_fwd_hit           bit0 rs1 forwarded, bit1 rs2 forwarded
//   o_fwd_cnt           (BYPASS_STAT_EN) saturating forwarding-cycle count
//   o_stall_cnt         (BYPASS_STAT_EN) saturating stall-cycle count
//
// Build option: define BYPASS_STAT_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module bypass_fwd_unit
  import bypass_fwd_unit_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW,
  parameter int DEPTH  = 3
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_flush,
  input  logic              i_wr_valid,
  input  logic [REG_AW-1:0] i_wr_addr,
  input  logic [XLEN-1:0]   i_wr_data,
  input  logic              i_wr_is_load,
  input  logic              i_ld_valid,
  input  logic [XLEN-1:0]   i_ld_data,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  input  logic [XLEN-1:0]   i_rf_rs1,
  input  logic [XLEN-1:0]   i_rf_rs2,
  output logic [XLEN-1:0]   o_opA,
  output logic [XLEN-1:0]   o_opB,
  output logic              o_stall,
  output logic [1:0]        o_fwd_hit
`ifdef BYPASS_STAT_EN
  ,
  output logic [31:0]       o_fwd_cnt,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam int EW = ent_width(XLEN, REG_AW);
  localparam int AL = ent_addr_lsb(XLEN);
  localparam int PB = ent_pend_bit(XLEN, REG_AW);
  localparam int VB = ent_valid_bit(XLEN, REG_AW);

  logic [DEPTH*EW-1:0] hist_q;
  logic [DEPTH*EW-1:0] hist_d;
  logic                wr_cand_valid;
  logic                stall_rs1;
  logic                stall_rs2;

  // While reset is held the history is already clear; masking the incoming
  // write as well makes both operands pure register-file reads.
  assign wr_cand_valid = i_wr_valid & i_rstn;

  // Next history: shift, insert the new write at slot 0, then apply flush and
  // the load return on the shifted image.
  always_comb begin
    hist_d = hist_q;
    for (int k = DEPTH - 1; k > 0; k--) begin
      hist_d[k*EW +: EW] = hist_q[(k-1)*EW +: EW];
    end
    hist_d[VB]                   = i_wr_valid && (i_wr_addr != REG_AW'(X0_ADDR));
    hist_d[PB]                   = i_wr_is_load;
    hist_d[AL +: REG_AW]         = i_wr_addr;
    hist_d[ENT_DATA_LSB +: XLEN] = i_wr_data;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_flush) begin
        hist_d[k*EW + VB] = 1'b0;
      end
      if (i_ld_valid && hist_d[k*EW + PB]) begin
        hist_d[k*EW + PB]                   = 1'b0;
        hist_d[k*EW + ENT_DATA_LSB +: XLEN] = i_ld_data;
      end
    end
  end

  // NOTE: the history is a handful of flops, not a RAM, and is reset as a
  // whole so valid bits drop the instant i_rstn falls; sequential state uses
  // non-blocking assignments so every slot shifts from the old values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  bypass_match #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_match_rs1 (
    .i_hist       (hist_q),
    .i_wr_valid   (wr_cand_valid),
    .i_wr_is_load (i_wr_is_load),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_rs_addr    (i_rs1_addr),
    .i_rf_data    (i_rf_rs1),
    .o_op         (o_opA),
    .o_hit        (o_fwd_hit[0]),
    .o_stall      (stall_rs1)
  );

  bypass_match #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_match_rs2 (
    .i_hist       (hist_q),
    .i_wr_valid   (wr_cand_valid),
    .i_wr_is_load (i_wr_is_load),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_rs_addr    (i_rs2_addr),
    .i_rf_data    (i_rf_rs2),
    .o_op         (o_opB),
    .o_hit        (o_fwd_hit[1]),
    .o_stall      (stall_rs2)
  );

  assign o_stall = stall_rs1 | stall_rs2;

`ifdef BYPASS_STAT_EN
  logic [31:0] fwd_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (i_flush) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((o_fwd_hit != 2'b00) && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
      if (o_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign o_fwd_cnt   = fwd_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_bypass_fwd_unit.sv
module tb_bypass_fwd_unit;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;

  logic            clk;
  logic            rstn;
  logic            flush;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_is_load;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall;
  logic [1:0]      fwd_hit;
`ifdef BYPASS_STAT_EN
  logic [31:0]     fwd_cnt;
  logic [31:0]     stall_cnt;
`endif

  bypass_fwd_unit #(
    .XLEN   (XLEN),
    .REG_AW (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_flush      (flush),
    .i_wr_valid   (wr_valid),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_wr_is_load (wr_is_load),
    .i_ld_valid   (ld_valid),
    .i_ld_data    (ld_data),
    .i_rs1_addr   (rs1_addr),
    .i_rs2_addr   (rs2_addr),
    .i_rf_rs1     (rf_rs1),
    .i_rf_rs2     (rf_rs2),
    .o_opA        (op_a),
    .o_opB        (op_b),
    .o_stall      (stall),
    .o_fwd_hit    (fwd_hit)
`ifdef BYPASS_STAT_EN
    ,
    .o_fwd_cnt    (fwd_cnt),
    .o_stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            wv;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            wl;
    logic            lv;
    logic [XLEN-1:0] ld;
    logic [AW-1:0]   r1;
    logic [XLEN-1:0] f1;
    logic [AW-1:0]   r2;
    logic [XLEN-1:0] f2;
    logic            fl;
  } stim_t;

  typedef struct packed {
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            stl;
    logic [1:0]      hit;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference history, slot 0 newest.
  logic            m_v[DEPTH];
  logic            m_p[DEPTH];
  logic [AW-1:0]   m_a[DEPTH];
  logic [XLEN-1:0] m_d[DEPTH];
  int unsigned     m_fcnt;
  int unsigned     m_scnt;

  // Outputs sampled in the last step, for directed checks.
  logic [XLEN-1:0] s_opa;
  logic [XLEN-1:0] s_opb;
  logic            s_stall;
  logic [1:0]      s_hit;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0;
      m_p[k] = 1'b0;
      m_a[k] = '0;
      m_d[k] = '0;
    end
    m_fcnt = 0;
    m_scnt = 0;
  endtask

  function automatic logic m_any_pend();
    logic r = 1'b0;
    for (int k = 0; k < DEPTH; k++) r |= m_p[k];
    return r;
  endfunction

  task automatic m_resolve(input logic [AW-1:0] rs, input logic [XLEN-1:0] rf,
                           output logic [XLEN-1:0] op, output logic hit, output logic stl);
    op  = rf;
    hit = 1'b0;
    stl = 1'b0;
    if (rs == '0) return;
    if (rstn && wr_valid && wr_addr == rs) begin
      if (wr_is_load) stl = 1'b1;
      else begin op = wr_data; hit = 1'b1; end
      return;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (m_v[k] && m_a[k] == rs) begin
        if (m_p[k]) stl = 1'b1;
        else begin op = m_d[k]; hit = 1'b1; end
        return;
      end
    end
  endtask

  task automatic m_edge(input logic l_hit_any, input logic l_stall);
    if (!rstn) begin
      m_clear();
      return;
    end
    for (int k = DEPTH - 1; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_p[k] = m_p[k-1]; m_a[k] = m_a[k-1]; m_d[k] = m_d[k-1];
    end
    m_v[0] = wr_valid && (wr_addr != '0);
    m_p[0] = wr_is_load;
    m_a[0] = wr_addr;
    m_d[0] = wr_data;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) m_v[k] = 1'b0;
      if (ld_valid && m_p[k]) begin m_p[k] = 1'b0; m_d[k] = ld_data; end
    end
    if (flush) begin
      m_fcnt = 0;
      m_scnt = 0;
    end else begin
      if (l_hit_any && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      if (l_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    end
  endtask

  // Called at posedge+1: drive, push expectation, compare at negedge,
  // advance the model on the next posedge.
  task automatic step(input stim_t s, input string tag);
    exp_t e;
    exp_t got;
    logic h1, h2;
    wr_valid   = s.wv;
    wr_addr    = s.wa;
    wr_data    = s.wd;
    wr_is_load = s.wl;
    ld_valid   = s.lv;
    ld_data    = s.ld;
    rs1_addr   = s.r1;
    rf_rs1     = s.f1;
    rs2_addr   = s.r2;
    rf_rs2     = s.f2;
    flush      = s.fl;
    if (s.wl) check({tag, ".proto_one_pending"}, {63'd0, m_any_pend()}, 64'd0);
    m_resolve(s.r1, s.f1, e.opa, h1, e.stl);
    m_resolve(s.r2, s.f2, e.opb, h2, got.stl);
    e.stl = e.stl | got.stl;
    e.hit = {h2, h1};
    exp_q.push_back(e);
    @(negedge clk);
    s_opa   = op_a;
    s_opb   = op_b;
    s_stall = stall;
    s_hit   = fwd_hit;
    got = exp_q.pop_front();
    check({tag, ".opA"},   s_opa,   got.opa);
    check({tag, ".opB"},   s_opb,   got.opb);
    check({tag, ".stall"}, s_stall, got.stl);
    check({tag, ".hit"},   s_hit,   got.hit);
    @(posedge clk);
    m_edge(got.hit != 2'b00, got.stl);
    #1;
`ifdef BYPASS_STAT_EN
    check({tag, ".fwd_cnt"},   fwd_cnt,   m_fcnt);
    check({tag, ".stall_cnt"}, stall_cnt, m_scnt);
`endif
  endtask

  initial begin
    stim_t s;
    m_clear();
    rstn = 1'b0; flush = 1'b0; wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD;
    wr_is_load = 1'b0; ld_valid = 1'b0; ld_data = '0;
    rs1_addr = 5'd5; rf_rs1 = 32'h11; rs2_addr = 5'd5; rf_rs2 = 32'h22;

    // Outputs while reset is held: register-file pass-through.
    #2;
    check("rst.opA", op_a, 32'h11);
    check("rst.opB", op_b, 32'h22);
    check("rst.stall", stall, 1'b0);
    check("rst.hit", fwd_hit, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    // Plain register-file read.
    s = '0; s.r1 = 5'd5; s.f1 = 32'h11;
    step(s, "tp1");
    check("tp1.opA_const", s_opa, 32'h11);
    check("tp1.hit_const", s_hit, 2'b00);

    // Youngest of two writes to x5 wins.
    s = '0; s.wv = 1; s.wa = 5'd5; s.wd = 32'hAAAA; step(s, "tp2a");
    s = '0; s.wv = 1; s.wa = 5'd5; s.wd = 32'hBBBB; step(s, "tp2b");
    s = '0; s.r1 = 5'd5; s.f1 = 32'h99;             step(s, "tp2c");
    check("tp2.opA_const", s_opa, 32'hBBBB);
    check("tp2.hit0_const", s_hit[0], 1'b1);

    // x0 is never forwarded.
    s = '0; s.wv = 1; s.wa = 5'd0; s.wd = 32'h1234; step(s, "tp3a");
    s = '0; s.r1 = 5'd0; s.f1 = 32'h0;              step(s, "tp3b");
    check("tp3.x0_opA_const", s_opa, 32'h0);
    check("tp3.x0_hit_const", s_hit, 2'b00);

    // Entry lives in slot DEPTH-1 three cycles after the write, gone at four.
    s = '0; s.wv = 1; s.wa = 5'd7; s.wd = 32'h77; step(s, "tp3c");
    s = '0; step(s, "tp3d");
    s = '0; step(s, "tp3e");
    s = '0; s.r2 = 5'd7; s.f2 = 32'h5; step(s, "tp3f");
    check("tp3.oldest_opB_const", s_opb, 32'h77);
    check("tp3.oldest_hit_const", s_hit[1], 1'b1);
    s = '0; s.r2 = 5'd7; s.f2 = 32'h5; step(s, "tp3g");
    check("tp3.dropped_opB_const", s_opb, 32'h5);
    check("tp3.dropped_hit_const", s_hit[1], 1'b0);

    // Load-use hazard, including the same-cycle return.
    s = '0; s.wv = 1; s.wa = 5'd9; s.wd = 32'hFFFF; s.wl = 1; step(s, "tp4a");
    s = '0; s.r2 = 5'd9; s.f2 = 32'h1; step(s, "tp4b");
    check("tp4.pend_stall_const", s_stall, 1'b1);
    check("tp4.pend_opB_const", s_opb, 32'h1);
    s = '0; s.r2 = 5'd9; s.f2 = 32'h1; s.lv = 1; s.ld = 32'hCAFE; step(s, "tp4c");
    check("tp4.ret_cycle_stall_const", s_stall, 1'b1);
    s = '0; s.r2 = 5'd9; s.f2 = 32'h1; step(s, "tp4d");
    check("tp4.after_stall_const", s_stall, 1'b0);
    check("tp4.after_opB_const", s_opb, 32'hCAFE);

    // Flush: lookup in the flush cycle sees the old history; afterwards all gone.
    s = '0; s.wv = 1; s.wa = 5'd4; s.wd = 32'h44; step(s, "tp5a");
    s = '0; s.wv = 1; s.wa = 5'd3; s.wd = 32'h55; s.fl = 1; s.r1 = 5'd4; s.f1 = 32'h0;
    step(s, "tp5b");
    check("tp5.preflush_opA_const", s_opa, 32'h44);
    s = '0; s.r1 = 5'd3; s.f1 = 32'h10; s.r2 = 5'd4; s.f2 = 32'h20; step(s, "tp5c");
    check("tp5.flushed_opA_const", s_opa, 32'h10);
    check("tp5.flushed_opB_const", s_opb, 32'h20);
    check("tp5.flushed_hit_const", s_hit, 2'b00);

    // Asynchronous reset mid-history.
    s = '0; s.wv = 1; s.wa = 5'd6; s.wd = 32'h66; step(s, "tp6a");
    wr_valid = 1'b0; rs1_addr = 5'd6; rf_rs1 = 32'h1; rs2_addr = '0; rf_rs2 = '0;
    #1;
    check("tp6.before_rst_hit", fwd_hit, 2'b01);
    check("tp6.before_rst_opA", op_a, 32'h66);
    rstn = 1'b0;
    #1;
    check("tp6.in_rst_hit", fwd_hit, 2'b00);
    check("tp6.in_rst_opA", op_a, 32'h1);
    m_clear();
`ifdef BYPASS_STAT_EN
    check("tp6.in_rst_fwd_cnt", fwd_cnt, 32'd0);
    check("tp6.in_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;

`ifdef BYPASS_STAT_EN
    // Four forwarding cycles then two stall cycles, then flush.
    s = '0; s.wv = 1; s.wa = 5'd8; s.wd = 32'h8; s.r1 = 5'd8; step(s, "st_a");
    s = '0; s.r1 = 5'd8; step(s, "st_b");
    s = '0; s.r1 = 5'd8; step(s, "st_c");
    s = '0; s.r1 = 5'd8; s.wv = 1; s.wa = 5'd10; s.wl = 1; step(s, "st_d");
    s = '0; s.r2 = 5'd10; step(s, "st_e");
    s = '0; s.r2 = 5'd10; s.lv = 1; s.ld = 32'hD00D; step(s, "st_f");
    check("stat.fwd_cnt_const", fwd_cnt, 32'd4);
    check("stat.stall_cnt_const", stall_cnt, 32'd2);
    s = '0; s.fl = 1; step(s, "st_g");
    check("stat.flush_fwd_cnt_const", fwd_cnt, 32'd0);
    check("stat.flush_stall_cnt_const", stall_cnt, 32'd0);
`endif

    // Random traffic on a small register set, load protocol respected.
    for (int n = 0; n < 300; n++) begin
      s = '0;
      s.wv = ($urandom_range(0, 2) != 0);
      s.wa = AW'($urandom_range(0, 7));
      s.wd = $urandom;
      if (!m_any_pend() && $urandom_range(0, 4) == 0) begin
        s.wv = 1'b1;
        s.wl = 1'b1;
      end
      if (m_p[DEPTH-2]) s.lv = 1'b1;
      else if (m_any_pend()) s.lv = ($urandom_range(0, 1) == 1);
      s.ld = $urandom;
      s.r1 = AW'($urandom_range(0, 7));
      s.f1 = $urandom;
      s.r2 = AW'($urandom_range(0, 7));
      s.f2 = $urandom;
      s.fl = ($urandom_range(0, 15) == 0);
      step(s, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
